// File: rtl/popcount_onehot_pipe.sv
// Two-stage pipelined population count with one-hot result, a saturating
// running accumulator and an optional windowed total that closes every WIN samples.
module popcount_onehot_pipe #(
  parameter int N   = 4,
  parameter int CW  = $clog2(N + 1),
  parameter int AW  = 16,
  parameter int WIN = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [N-1:0]  in_data_i,
  input  logic          win_mode_i,
  input  logic          clear_i,
  output logic          out_valid_o,
  output logic [CW-1:0] out_count_o,
  output logic [N:0]    out_onehot_o,
  output logic [AW-1:0] acc_total_o,
  output logic          acc_sat_o,
  output logic          win_done_o
);

  localparam int WCW = $clog2(WIN + 1);

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] d);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int i = 0; i < N; i++) begin
      c = c + CW'(d[i]);
    end
    return c;
  endfunction

  logic           s1_valid_q;
  logic [CW-1:0]  s1_count_q;
  logic           out_valid_q;
  logic [CW-1:0]  out_count_q;
  logic [N:0]     out_onehot_q;
  logic [AW-1:0]  acc_q, acc_d;
  logic           sat_q, sat_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           done_q, done_d;
  logic           restart_q, restart_d;
  logic           mode_q;
  logic [AW-1:0]  base_s;
  logic [AW:0]    sum_s;
  logic           mode_chg_s;

  // Stage 1: count the incoming sample; the count holds while no sample arrives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_count_q <= {CW{1'b0}};
    end else begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_count_q <= popcount(in_data_i);
      end
    end
  end

  // Stage 2: present the count in binary and one-hot form.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_count_q  <= {CW{1'b0}};
      out_onehot_q <= {{N{1'b0}}, 1'b1};
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_count_q  <= s1_count_q;
        out_onehot_q <= {{N{1'b0}}, 1'b1} << s1_count_q;
      end
    end
  end

  // Accumulator, saturation and window bookkeeping; restart_q means the
  // previous valid closed a window, so the next one starts a fresh total.
  always_comb begin
    mode_chg_s = (win_mode_i != mode_q);
    base_s     = restart_q ? {AW{1'b0}} : acc_q;
    sum_s      = {1'b0, base_s} + (AW + 1)'(s1_count_q);
    acc_d      = acc_q;
    sat_d      = sat_q;
    wcnt_d     = wcnt_q;
    done_d     = 1'b0;
    restart_d  = restart_q;
    if (clear_i) begin
      acc_d     = {AW{1'b0}};
      sat_d     = 1'b0;
      wcnt_d    = {WCW{1'b0}};
      restart_d = 1'b0;
    end else begin
      if (s1_valid_q) begin
        if (sum_s[AW]) begin
          acc_d = {AW{1'b1}};
          sat_d = 1'b1;
        end else begin
          acc_d = sum_s[AW-1:0];
          sat_d = restart_q ? 1'b0 : sat_q;
        end
        restart_d = 1'b0;
        if (mode_q && !mode_chg_s) begin
          if (wcnt_q == WCW'(WIN - 1)) begin
            wcnt_d    = {WCW{1'b0}};
            done_d    = 1'b1;
            restart_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end else begin
          wcnt_d = {WCW{1'b0}};
        end
      end else begin
        acc_d = acc_q;
      end
      if (mode_chg_s) begin
        wcnt_d    = {WCW{1'b0}};
        restart_d = 1'b0;
      end else begin
        restart_d = restart_d;
      end
    end
  end

  // Accumulator and window state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q     <= {AW{1'b0}};
      sat_q     <= 1'b0;
      wcnt_q    <= {WCW{1'b0}};
      done_q    <= 1'b0;
      restart_q <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      wcnt_q    <= wcnt_d;
      done_q    <= done_d;
      restart_q <= restart_d;
      mode_q    <= win_mode_i;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_count_o  = out_count_q;
  assign out_onehot_o = out_onehot_q;
  assign acc_total_o  = acc_q;
  assign acc_sat_o    = sat_q;
  assign win_done_o   = done_q;

endmodule
